demux_1_4_tdm: RTL

Registered 1:4 demultiplexer that steers a single input stream onto four output lanes, either by an explicit select or by a free-running round-robin slot counter. It is the receive-side counterpart of the team's 4:1 mux: a stream time-division multiplexed as lane 0, 1, 2, 3 is split back into lanes and reassembled into 4-lane frames. It sits between a serial/TDM source and lane-parallel consumers.

---
 rtl/demux_pkg.sv | 25 ++
 rtl/demux_slot_ctr.sv | 48 ++++
 rtl/demux_1_4_tdm.sv | 85 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared lane count, slot encoding and strobe decode for the 1:4 TDM demux.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    // Round-robin slot; each state names the lane the next beat will fill.
    typedef enum logic [SEL_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } slot_t;

    // One-hot lane decode used for out_strobe.
    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] lane);
        logic [LANES-1:0] r;
        r       = '0;
        r[lane] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Mod-4 round-robin slot counter with sync / mode-entry realign to lane 0.
// Latency: slot updates on the edge that consumes a beat; wr_slot is combinational.
// Backpressure: none; advances on every valid beat in round-robin mode.
module demux_slot_ctr
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rr_mode,
    input  logic  sync,
    input  logic  adv,
    output slot_t slot,
    output slot_t wr_slot
);

    slot_t slot_q;
    slot_t slot_d;
    logic  rr_mode_q;
    logic  rr_mode_d;
    logic  realign;

    // Realign on explicit sync or a 0->1 mode edge; a beat in the same cycle lands in lane 0.
    always_comb begin
        rr_mode_d = rr_mode;
        realign   = rr_mode && (sync || !rr_mode_q);
        wr_slot   = realign ? S0 : slot_q;
        slot_d    = slot_q;
        if (rr_mode && adv) begin
            slot_d = slot_t'(wr_slot + 2'd1);
        end else if (realign) begin
            slot_d = S0;
        end
    end

    // Slot state and previous-mode flag; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= S0;
            rr_mode_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            rr_mode_q <= rr_mode_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/demux_1_4_tdm.sv
// Registered 1:4 demux: addressed (sel) or round-robin lane steering with 4-lane frame capture.
// Latency: 1 cycle din -> lane/strobe/frame.
// Backpressure: none; one beat per cycle always accepted.
module demux_1_4_tdm
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   rr_mode,
    input  logic                   sync,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       out_strobe,
    output logic [LANES*WIDTH-1:0] frame,
    output logic                   frame_valid,
    output logic [SEL_W-1:0]       slot
);

    slot_t                   slot_cur;
    slot_t                   wr_slot;
    logic [SEL_W-1:0]        wr_lane;

    logic [LANES*WIDTH-1:0]  out_q,    out_d;
    logic [LANES-1:0]        strobe_q, strobe_d;
    logic [LANES*WIDTH-1:0]  frame_q,  frame_d;
    logic                    fv_q,     fv_d;

    demux_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (rr_mode),
        .sync    (sync),
        .adv     (din_valid),
        .slot    (slot_cur),
        .wr_slot (wr_slot)
    );

    // Steer the beat into one lane; only an S3 round-robin beat completes a frame.
    always_comb begin
        out_d    = out_q;
        strobe_d = '0;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        wr_lane  = rr_mode ? wr_slot : sel;
        if (din_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane == SEL_W'(i)) begin
                    out_d[i*WIDTH +: WIDTH] = din;
                end
            end
            strobe_d = lane_onehot(wr_lane);
            if (rr_mode && (wr_slot == S3)) begin
                // Fresh lane-3 beat plus the lanes already written this frame.
                frame_d = {din, out_q[3*WIDTH-1:0]};
                fv_d    = 1'b1;
            end
        end
    end

    // Lane, strobe and frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            strobe_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
        end
    end

    assign out         = out_q;
    assign out_strobe  = strobe_q;
    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign slot        = slot_cur;

endmodule
